// File: rtl/snoop_pkg.sv
// Shared types for the snoop transaction controller: AC/CR field types, CR bit indices and
// the controller state enum.
package snoop_pkg;

   typedef logic [3:0] acsnoop_t;
   typedef logic [2:0] acprot_t;
   typedef logic [4:0] crresp_t;

   localparam int unsigned CR_DT  = 0;
   localparam int unsigned CR_ERR = 1;
   localparam int unsigned CR_PD  = 2;
   localparam int unsigned CR_IS  = 3;
   localparam int unsigned CR_WU  = 4;

   localparam acsnoop_t ACSNOOP_READ_ONCE      = 4'h0;
   localparam acsnoop_t ACSNOOP_READ_SHARED    = 4'h1;
   localparam acsnoop_t ACSNOOP_CLEAN_INVALID  = 4'h9;
   localparam acsnoop_t ACSNOOP_MAKE_INVALID   = 4'hD;

   typedef enum logic [2:0] {
      StIdle,
      StAcSend,
      StCrWait,
      StCdFwd,
      StRsp
   } snoop_txn_state_e;

   function automatic logic cr_has_data(crresp_t resp);
      return resp[CR_DT];
   endfunction

endpackage

// File: rtl/snoop_txn_ctrl_if.sv
// Snoop bus (AC address, CR response, CD data channels) between the controller and the
// snooped master port.
interface snoop_txn_ctrl_if
   import snoop_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
) ();

   logic                  ac_valid;
   logic                  ac_ready;
   logic [ADDR_WIDTH-1:0] ac_addr;
   acsnoop_t              ac_snoop;
   acprot_t               ac_prot;

   logic                  cr_valid;
   logic                  cr_ready;
   crresp_t               cr_resp;

   logic                  cd_valid;
   logic                  cd_ready;
   logic [DATA_WIDTH-1:0] cd_data;
   logic                  cd_last;

   modport master (
      output ac_valid, ac_addr, ac_snoop, ac_prot, cr_ready, cd_ready,
      input  ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last
   );

   modport slave (
      input  ac_valid, ac_addr, ac_snoop, ac_prot, cr_ready, cd_ready,
      output ac_ready, cr_valid, cr_resp, cd_valid, cd_data, cd_last
   );

endinterface

// File: rtl/snoop_txn_ctrl.sv
// Single-outstanding snoop transaction controller: request -> AC -> CR -> optional CD forward
// -> completion. Optional CD last checking is enabled by SNOOP_TXN_CTRL_LAST_CHECK_EN.
module snoop_txn_ctrl
   import snoop_pkg::*;
#(
   parameter int unsigned SNOOP_ADDR_WIDTH = 64,
   parameter int unsigned SNOOP_DATA_WIDTH = 64,
   parameter int unsigned CD_BEATS         = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,

   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [SNOOP_ADDR_WIDTH-1:0] req_addr_i,
   input  acsnoop_t                    req_snoop_i,
   input  acprot_t                     req_prot_i,

   snoop_txn_ctrl_if.master            snoop_bus,

   output logic                        data_valid_o,
   input  logic                        data_ready_i,
   output logic [SNOOP_DATA_WIDTH-1:0] data_o,
   output logic                        data_last_o,

   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output crresp_t                     rsp_resp_o,
   output logic                        rsp_err_o
);

   localparam int unsigned CntW = $clog2(CD_BEATS) + 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(CD_BEATS - 1);

   snoop_txn_state_e state_q, state_d;

   logic [SNOOP_ADDR_WIDTH-1:0] addr_q;
   acsnoop_t                    snoop_q;
   acprot_t                     prot_q;
   crresp_t                     resp_q;
   logic [CntW-1:0]             cnt_q;

   logic idle_ready;
   logic ac_valid;
   logic cr_ready;
   logic cd_ready;
   logic cd_hs;
   logic last_beat;

   assign last_beat = (cnt_q == LastBeat);
   assign cd_hs     = (state_q == StCdFwd) && snoop_bus.cd_valid && data_ready_i;

   always_comb begin
      state_d      = state_q;
      idle_ready   = 1'b0;
      ac_valid     = 1'b0;
      cr_ready     = 1'b0;
      cd_ready     = 1'b0;
      data_valid_o = 1'b0;
      data_o       = '0;
      data_last_o  = 1'b0;
      rsp_valid_o  = 1'b0;

      unique case (state_q)
         StIdle: begin
            idle_ready = 1'b1;
            if (req_valid_i) state_d = StAcSend;
         end
         StAcSend: begin
            ac_valid = 1'b1;
            if (snoop_bus.ac_ready) state_d = StCrWait;
         end
         StCrWait: begin
            cr_ready = 1'b1;
            if (snoop_bus.cr_valid) begin
               state_d = cr_has_data(snoop_bus.cr_resp) ? StCdFwd : StRsp;
            end
         end
         StCdFwd: begin
            // Straight pass-through; the beat counter alone decides where the burst ends.
            data_valid_o = snoop_bus.cd_valid;
            cd_ready     = data_ready_i;
            data_o       = snoop_bus.cd_data;
            data_last_o  = last_beat;
            if (cd_hs && last_beat) state_d = StRsp;
         end
         StRsp: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign req_ready_o        = idle_ready & rst_ni;
   assign snoop_bus.ac_valid = ac_valid;
   assign snoop_bus.ac_addr  = addr_q;
   assign snoop_bus.ac_snoop = snoop_q;
   assign snoop_bus.ac_prot  = prot_q;
   assign snoop_bus.cr_ready = cr_ready;
   assign snoop_bus.cd_ready = cd_ready;
   assign rsp_resp_o         = resp_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         addr_q  <= '0;
         snoop_q <= '0;
         prot_q  <= '0;
         resp_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && req_valid_i) begin
            addr_q  <= req_addr_i;
            snoop_q <= req_snoop_i;
            prot_q  <= req_prot_i;
         end
         if (state_q == StCrWait && snoop_bus.cr_valid) begin
            resp_q <= snoop_bus.cr_resp;
         end
         if (cd_hs) begin
            cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
         end
      end
   end

`ifdef SNOOP_TXN_CTRL_LAST_CHECK_EN
   logic err_q;
   logic last_mismatch;

   assign last_mismatch = (snoop_bus.cd_last != last_beat);
   assign rsp_err_o     = err_q;

   // Sticky across the burst; cleared only once the completion has been taken.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (state_q == StRsp && rsp_ready_i) begin
         err_q <= 1'b0;
      end else if (cd_hs && last_mismatch) begin
         err_q <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni && cd_hs && last_mismatch) begin
         $error("snoop_txn_ctrl: cd_last mismatch at beat %0d", cnt_q);
      end
   end
`endif
`else
   logic unused_cd_last;
   assign unused_cd_last = snoop_bus.cd_last;
   assign rsp_err_o      = 1'b0;
`endif

endmodule
